// File: rtl/gpio_intc_pkg.sv
// Shared constants for the GPIO interrupt controller: FSM state encoding and
// register map addresses.
package gpio_intc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  // Plain vector constants keep the state register a simple logic [1:0]
  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_REQ  = S_REQ;
  localparam logic [1:0] ST_ACK  = S_ACK;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_POL  = 2'd2;
  localparam logic [1:0] ADDR_PEND = 2'd3;

endpackage

// File: rtl/gpio_intc_nch_if.sv
// Register bus of the GPIO interrupt controller: chip-select framed
// read/write with separate accept and read-data-valid strobes.
interface gpio_intc_nch_if #(
  parameter int DW = 16
);
  logic          i_csn_50m;
  logic          i_wr_50m;
  logic          i_rd_50m;
  logic [1:0]    i_addr_50m;
  logic [DW-1:0] i_datin_50m;
  logic [DW-1:0] o_datout_50m;
  logic          wr_valid;
  logic          rd_valid;

  modport master (
    output i_csn_50m, i_wr_50m, i_rd_50m, i_addr_50m, i_datin_50m,
    input  o_datout_50m, wr_valid, rd_valid
  );

  modport slave (
    input  i_csn_50m, i_wr_50m, i_rd_50m, i_addr_50m, i_datin_50m,
    output o_datout_50m, wr_valid, rd_valid
  );
endinterface

// File: rtl/gpio_intc_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of the request vector.
module gpio_intc_prio_enc #(
  parameter  int N_CH = 8,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_vec,
  output logic [CW-1:0]   idx,
  output logic            vld
);

  // Scanning downward lets the lowest set bit be the last (winning) assignment
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        idx = CW'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_intc_nch.sv
// N-channel GPIO interrupt controller: synchronised sources, per-channel
// mask/edge/polarity, fixed-priority INTR/INTA_N handshake, register bus.
module gpio_intc_nch
  import gpio_intc_pkg::*;
#(
  parameter  int N_CH   = 8,
  parameter  int DW     = 16,
  parameter  int RD_LAT = 7,
  localparam int CW     = $clog2(N_CH)
) (
  input  logic            clk_50m,
  input  logic            rstn_50m,
  input  logic [N_CH-1:0] gpio_in,
  gpio_intc_nch_if.slave  bus,
  output logic            INTR,
  input  logic            INTA_N,
  output logic [CW-1:0]   INT_CODE
);

  logic [N_CH-1:0] gpio_p0, gpio_p1, gpio_p2;
  logic            csn_d, inta_d;
  logic [N_CH-1:0] mask_r, edge_r, pol_r, pend_e;
  logic            start, wr_hit, rd_hit, inta_fall;
  logic [N_CH-1:0] edge_set, lvl_pend, pend_all, req_vec, w1c, ack_clr;
  logic [CW-1:0]   win_idx;
  logic            win_vld;
  logic [1:0]      state;
  logic [DW-1:0]   rd_data;
  logic            vld_p [RD_LAT];
  logic [DW-1:0]   dat_p [RD_LAT];

  // Stage boundary: two-flop synchroniser plus previous synchronised value
  always_ff @(posedge clk_50m or negedge rstn_50m) begin
    if (!rstn_50m) begin
      gpio_p0 <= '0;
      gpio_p1 <= '0;
      gpio_p2 <= '0;
      csn_d   <= 1'b1;
      inta_d  <= 1'b1;
    end else begin
      gpio_p0 <= gpio_in;
      gpio_p1 <= gpio_p0;
      gpio_p2 <= gpio_p1;
      csn_d   <= bus.i_csn_50m;
      inta_d  <= INTA_N;
    end
  end

  assign start     = ~bus.i_csn_50m & csn_d;
  assign wr_hit    = start & bus.i_wr_50m;
  assign rd_hit    = start & bus.i_rd_50m & ~bus.i_wr_50m;
  assign inta_fall = ~INTA_N & inta_d;
  assign bus.wr_valid = wr_hit & rstn_50m;

  assign edge_set = edge_r & ((pol_r & gpio_p1 & ~gpio_p2) | (~pol_r & ~gpio_p1 & gpio_p2));
  assign lvl_pend = ~edge_r & ~(gpio_p1 ^ pol_r);
  // Stale edge bits of channels just switched to level must not leak out
  assign pend_all = (pend_e & edge_r) | lvl_pend;
  assign req_vec  = pend_all & mask_r;

  assign w1c     = (wr_hit && bus.i_addr_50m == ADDR_PEND) ? bus.i_datin_50m[N_CH-1:0] : '0;
  assign ack_clr = (state == ST_REQ && inta_fall) ? (N_CH'(1) << INT_CODE) : '0;

  always_ff @(posedge clk_50m or negedge rstn_50m) begin
    if (!rstn_50m) begin
      mask_r <= '0;
      edge_r <= '0;
      pol_r  <= '1;
    end else if (wr_hit) begin
      case (bus.i_addr_50m)
        ADDR_MASK: mask_r <= bus.i_datin_50m[N_CH-1:0];
        ADDR_EDGE: edge_r <= bus.i_datin_50m[N_CH-1:0];
        ADDR_POL:  pol_r  <= bus.i_datin_50m[N_CH-1:0];
        default:   ;
      endcase
    end
  end

  // A new edge in the same cycle as a clear keeps the bit set
  always_ff @(posedge clk_50m or negedge rstn_50m) begin
    if (!rstn_50m) pend_e <= '0;
    else           pend_e <= ((pend_e & ~(w1c | ack_clr)) | edge_set) & edge_r;
  end

  gpio_intc_prio_enc #(.N_CH(N_CH)) u_prio_enc (
    .req_vec (req_vec),
    .idx     (win_idx),
    .vld     (win_vld)
  );

  always_ff @(posedge clk_50m or negedge rstn_50m) begin
    if (!rstn_50m) begin
      state    <= ST_IDLE;
      INT_CODE <= '0;
    end else begin
      case (state)
        ST_IDLE: if (win_vld) begin
          state    <= ST_REQ;
          INT_CODE <= win_idx;
        end
        ST_REQ: begin
          if (inta_fall)     state <= ST_ACK;
          else if (!win_vld) state <= ST_IDLE;
        end
        ST_ACK:  if (INTA_N) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign INTR = (state == ST_REQ);

  always_comb begin
    rd_data = '0;
    case (bus.i_addr_50m)
      ADDR_MASK: rd_data = DW'(mask_r);
      ADDR_EDGE: rd_data = DW'(edge_r);
      ADDR_POL:  rd_data = DW'(pol_r);
      default:   rd_data = DW'(pend_all);
    endcase
  end

  // Stage boundary: read pipeline, valid flushed by reset, data gated by valid
  always_ff @(posedge clk_50m or negedge rstn_50m) begin
    if (!rstn_50m) begin
      for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= rd_hit;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk_50m) begin
    dat_p[0] <= rd_data;
    for (int i = 1; i < RD_LAT; i++) dat_p[i] <= dat_p[i-1];
  end

  assign bus.rd_valid     = vld_p[RD_LAT-1];
  assign bus.o_datout_50m = vld_p[RD_LAT-1] ? dat_p[RD_LAT-1] : '0;

endmodule

// File: doc/gpio_intc_nch.md
GPIO_INTC_NCH -- requirements
Module: gpio_intc_nch

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of GPIO interrupt channels (2..32).
REQ-002 SHALL have parameter DW, default 16, bus data width (DW >= N_CH).
REQ-003 SHALL have parameter RD_LAT, default 7, cycles from read-strobe sample to rd_valid.
REQ-004 SHALL derive localparam CW = $clog2(N_CH), INT_CODE width.
REQ-005 Ports (name direction width meaning):
- clk_50m  in  1  single clock, rising edge.
- rstn_50m  in  1  asynchronous active-low reset.
- gpio_in  in  N_CH  asynchronous GPIO interrupt sources.
- i_csn_50m  in  1  bus chip select, active low.
- i_wr_50m  in  1  write qualifier.
- i_rd_50m  in  1  read qualifier.
- i_addr_50m  in  2  register address.
- i_datin_50m  in  DW  write data.
- o_datout_50m  out  DW  read data.
- wr_valid  out  1  write accepted strobe.
- rd_valid  out  1  read data valid strobe.
- INTR  out  1  interrupt request, active high.
- INTA_N  in  1  interrupt acknowledge, active low.
- INT_CODE  out  CW  index of requesting channel.

Function
REQ-006 SHALL pass each gpio_in bit through a 2-flop synchroniser; all detection uses synchronised values.
REQ-007 Registers: 0 MASK (1=enabled, rw), 1 EDGE (1=edge, 0=level, rw), 2 POL (1=rising/high, 0=falling/low, rw), 3 PEND (read; write-1-to-clear, edge channels only); bits above N_CH read 0.
REQ-008 Bus transaction starts on cycle where i_csn_50m falls (low now, high previous cycle); other cycles ignored.
REQ-009 Write: on start cycle with i_wr_50m=1, register updates that edge, wr_valid=1 same cycle combinationally, one cycle wide.
REQ-010 Read: on start cycle with i_rd_50m=1, data sampled that edge; o_datout_50m valid with rd_valid=1 exactly RD_LAT cycles later, one cycle; o_datout_50m=0 otherwise.
REQ-011 Start cycle with i_wr_50m=i_rd_50m=1: write wins, no read issued.
REQ-012 Edge channel: pending set on synchronised edge of POL polarity; cleared by W1C or by acknowledge of that channel; set and clear same cycle -> set wins.
REQ-013 Level channel: pending equals synchronised input at active level; W1C and acknowledge have no effect.
REQ-014 Request vector = PEND & MASK; lowest set index wins (fixed priority).
REQ-015 FSM states IDLE, REQ, ACK.
REQ-016 IDLE -> REQ when request vector nonzero; INT_CODE latched to winner on that transition.
REQ-017 REQ: INTR=1, INT_CODE held stable; new higher-priority requests do not change INT_CODE.
REQ-018 REQ -> ACK on INTA_N falling edge: INTR=0 next cycle; edge pending bit of INT_CODE cleared same edge.
REQ-019 ACK -> IDLE when INTA_N=1; INTR stays 0 in ACK.
REQ-020 REQ with request vector cleared (mask/W1C) before ack: SHALL return to IDLE, INTR=0 next cycle.
REQ-021 INTA_N falling while IDLE or ACK SHALL be ignored.

Reset
REQ-022 On rstn_50m=0, immediately: INTR=0, INT_CODE=0, o_datout_50m=0, wr_valid=0, rd_valid=0, MASK=0, EDGE=0, POL=all 1, PEND=0, synchronisers 0, FSM=IDLE.
REQ-023 Reset mid-read SHALL flush the read pipeline; no rd_valid after release for a pre-reset read.

Structure
REQ-024 Package gpio_intc_pkg SHALL hold FSM state enum and register address constants.
REQ-025 Fixed-priority encoder SHALL be sub-module gpio_intc_prio_enc (N_CH-wide vector -> CW index + valid).

Verification
REQ-026 Reset: hold rstn_50m=0 10 cycles -> INTR=0, INT_CODE=0, o_datout_50m=0 every cycle.
REQ-027 Write MASK=0x00FF, read addr 0 -> wr_valid on csn-fall cycle; rd_valid and data 0x00FF exactly 7 cycles after read start.
REQ-028 Rising edge on gpio_in[3], MASK=0x08, EDGE=0x08 -> INTR=1, INT_CODE=3 within 4 cycles; INTA_N falls -> INTR=0 next cycle, PEND reads 0.
REQ-029 Edges on channels 5 and 2 same cycle, both enabled -> INT_CODE=2 first; after ack cycle completes, INT_CODE=5.
REQ-030 Level channel 1 held high, ack -> INTR re-asserts with INT_CODE=1 after INTA_N returns high; W1C 0x02 leaves PEND bit 1 set.
REQ-031 Assert rstn_50m low 3 cycles after read start -> no rd_valid after release; INTR=0.
